// File: rtl/tube_pkg.sv
// Shared types and constants for the drift-tube event builder.
package tube_pkg;

    localparam int DEF_N_CH        = 32;
    localparam int DEF_TS_W        = 8;
    localparam int DEF_WINDOW      = 200;
    localparam int DEF_SYNC_STAGES = 2;

    // Layout of a hit word: channel index in the upper byte, time in the lower byte.
    localparam int CH_MSB = 15;
    localparam int CH_LSB = 8;
    localparam int TS_MSB = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        DRAIN_HDR = 3'd2,
        DRAIN_HIT = 3'd3,
        DRAIN_TRL = 3'd4
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/tube_event_builder_edge_sync.sv
// Multi-flop synchroniser for asynchronous inputs with a one-cycle rising-edge pulse.
module edge_sync
    import tube_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES-1:0][WIDTH-1:0] chain_d;
    logic [WIDTH-1:0]             prev_q;
    logic [WIDTH-1:0]             prev_d;

    // Shift the raw input down the chain; remember the last synchronised sample.
    always_comb begin
        chain_d[0] = async_i;
        for (int s = 1; s < STAGES; s++) begin
            chain_d[s] = chain_q[s-1];
        end
        prev_d = chain_q[STAGES-1];
    end

    // Synchroniser and history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_o = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tube_event_builder.sv
// Drift-tube event builder: records first-hit times per channel after a
// scintillator trigger and streams header / hit words / trailer downstream.
module tube_event_builder
    import tube_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int TS_W        = DEF_TS_W,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            clk100,
    input  logic            rst_n,
    input  logic            scin_coin,
    input  logic [N_CH-1:0] tube_hit,
    output logic [15:0]     out_data,
    output logic            out_sof,
    output logic            out_eof,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic [15:0]     missed_trig
);

    localparam int                IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TS_W-1:0]   TS_LAST  = TS_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_CH - 1);

    if ((TS_W > 8) || (TS_W < 1)) begin : g_bad_ts_w
        $error("tube_event_builder: TS_W must be in 1..8");
    end
    if ((N_CH > 256) || (N_CH < 1)) begin : g_bad_n_ch
        $error("tube_event_builder: N_CH must be in 1..256");
    end
    if ((WINDOW > (1 << TS_W)) || (WINDOW < 2)) begin : g_bad_window
        $error("tube_event_builder: WINDOW must be in 2..2**TS_W");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("tube_event_builder: SYNC_STAGES must be at least 2");
    end

    logic                       trig_p;
    logic [N_CH-1:0]            tube_p;

    state_e                     state_q,     state_d;
    logic [TS_W-1:0]            ts_q,        ts_d;
    logic [N_CH-1:0]            hit_q,       hit_d;
    logic [N_CH-1:0][TS_W-1:0]  hit_ts_q,    hit_ts_d;
    logic [IDX_W-1:0]           scan_q,      scan_d;
    logic [15:0]                hit_cnt_q,   hit_cnt_d;
    logic [15:0]                evt_q,       evt_d;
    logic [15:0]                missed_q,    missed_d;
    logic [15:0]                out_data_q,  out_data_d;
    logic                       out_sof_q,   out_sof_d;
    logic                       out_eof_q,   out_eof_d;
    logic                       out_valid_q, out_valid_d;
    logic                       busy_q,      busy_d;

    logic                       xfer_s;
    logic                       slot_free_s;
    logic [15:0]                hit_word_s;

    edge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_trig_sync (
        .clk     (clk100),
        .rst_n   (rst_n),
        .async_i (scin_coin),
        .rise_o  (trig_p)
    );

    edge_sync #(.WIDTH(N_CH), .STAGES(SYNC_STAGES)) u_tube_sync (
        .clk     (clk100),
        .rst_n   (rst_n),
        .async_i (tube_hit),
        .rise_o  (tube_p)
    );

    // Output slot handshake: a word leaves on valid&ready; the slot can be
    // refilled in the same cycle it empties.
    always_comb begin
        xfer_s      = out_valid_q & out_ready;
        slot_free_s = ~out_valid_q | out_ready;
    end

    // Format the hit word for the channel currently under the scan pointer.
    always_comb begin
        hit_word_s                 = 16'd0;
        hit_word_s[CH_MSB:CH_LSB]  = 8'(scan_q);
        hit_word_s[TS_MSB:0]       = 8'(hit_ts_q[scan_q]);
    end

    // Count triggers that arrive while an event is still being captured or drained.
    always_comb begin
        if (trig_p && (state_q != IDLE)) begin
            missed_d = sat_inc16(missed_q);
        end else begin
            missed_d = missed_q;
        end
    end

    // Event FSM: capture, then header / hit words / trailer emission.
    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        hit_d       = hit_q;
        hit_ts_d    = hit_ts_q;
        scan_d      = scan_q;
        hit_cnt_d   = hit_cnt_q;
        evt_d       = evt_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        if (xfer_s) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            out_sof_d   = out_sof_q;
            out_eof_d   = out_eof_q;
        end

        case (state_q)
            IDLE: begin
                if (trig_p) begin
                    // The trigger cycle itself is timestamp 0, so hits seen now
                    // are stored as 0 and the first ARMED cycle is timestamp 1.
                    state_d  = ARMED;
                    ts_d     = TS_W'(1'b1);
                    hit_d    = tube_p;
                    hit_ts_d = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end

            ARMED: begin
                ts_d = ts_q + TS_W'(1'b1);
                for (int i = 0; i < N_CH; i++) begin
                    if (tube_p[i] && !hit_q[i]) begin
                        hit_d[i]    = 1'b1;
                        hit_ts_d[i] = ts_q;
                    end else begin
                        hit_d[i]    = hit_q[i];
                    end
                end
                if (ts_q == TS_LAST) begin
                    state_d = DRAIN_HDR;
                end else begin
                    state_d = ARMED;
                end
            end

            DRAIN_HDR: begin
                if (slot_free_s) begin
                    out_data_d  = evt_q;
                    out_sof_d   = 1'b1;
                    out_eof_d   = 1'b0;
                    out_valid_d = 1'b1;
                    scan_d      = '0;
                    hit_cnt_d   = 16'd0;
                    state_d     = DRAIN_HIT;
                end else begin
                    state_d     = DRAIN_HDR;
                end
            end

            DRAIN_HIT: begin
                if (slot_free_s) begin
                    if (hit_q[scan_q]) begin
                        out_data_d  = hit_word_s;
                        out_valid_d = 1'b1;
                        hit_cnt_d   = hit_cnt_q + 16'd1;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                    out_sof_d = 1'b0;
                    out_eof_d = 1'b0;
                    if (scan_q == IDX_LAST) begin
                        state_d = DRAIN_TRL;
                    end else begin
                        scan_d  = scan_q + IDX_W'(1'b1);
                    end
                end else begin
                    state_d = DRAIN_HIT;
                end
            end

            DRAIN_TRL: begin
                if (out_valid_q && out_eof_q) begin
                    // Trailer is on the bus; the event closes when it is taken.
                    if (out_ready) begin
                        evt_d   = evt_q + 16'd1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN_TRL;
                    end
                end else if (slot_free_s) begin
                    out_data_d  = hit_cnt_q;
                    out_sof_d   = 1'b0;
                    out_eof_d   = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = DRAIN_TRL;
                end
            end

            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_eof_d   = 1'b0;
            end
        endcase
    end

    // State, capture memory and registered stream outputs.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            hit_q       <= '0;
            hit_ts_q    <= '0;
            scan_q      <= '0;
            hit_cnt_q   <= 16'd0;
            evt_q       <= 16'd0;
            missed_q    <= 16'd0;
            out_data_q  <= 16'd0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            hit_q       <= hit_d;
            hit_ts_q    <= hit_ts_d;
            scan_q      <= scan_d;
            hit_cnt_q   <= hit_cnt_d;
            evt_q       <= evt_d;
            missed_q    <= missed_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign missed_trig = missed_q;

endmodule

// File: tb/tb_tube_event_builder.sv
// Self-checking bench for tube_event_builder: directed and randomised events
// compared against a list-based model of the expected word stream.
module tb_tube_event_builder;

    localparam int N_CH        = 32;
    localparam int TS_W        = 8;
    localparam int WINDOW      = 200;
    localparam int SYNC_STAGES = 2;

    logic            clk100 = 1'b0;
    logic            rst_n = 1'b0;
    logic            scin_coin = 1'b0;
    logic [N_CH-1:0] tube_hit = '0;
    logic            out_ready = 1'b1;
    logic [15:0]     out_data;
    logic            out_sof;
    logic            out_eof;
    logic            out_valid;
    logic            busy;
    logic [15:0]     missed_trig;

    int n_checks = 0;
    int n_pass   = 0;

    // Hit pulses of the current event, as (channel, timestamp) pairs.
    int p_ch[$];
    int p_ts[$];
    int extra_ts;
    int evt_exp;
    int missed_exp;

    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];

    int          ready_mode = 0;
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_word  = '0;

    tube_event_builder #(
        .N_CH(N_CH), .TS_W(TS_W), .WINDOW(WINDOW), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk100      (clk100),
        .rst_n       (rst_n),
        .scin_coin   (scin_coin),
        .tube_hit    (tube_hit),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .missed_trig (missed_trig)
    );

    initial forever #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready: always, random, or a 10-cycle hold on word 0x0311.
    initial begin
        forever begin
            @(posedge clk100);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0 && out_valid && out_data == 16'h0311) begin
                        out_ready = 1'b0;
                        stall_left--;
                        stall_seen++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Collect transferred words and verify the bus holds still while stalled.
    initial begin
        forever begin
            @(negedge clk100);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_word", {out_sof, out_eof, out_data}, prev_word);
                end
                if (out_valid && out_ready) got_q.push_back({out_sof, out_eof, out_data});
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_sof, out_eof, out_data};
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_event();
        p_ch.delete();
        p_ts.delete();
        extra_ts = 0;
    endtask

    task automatic add_hit(input int ch, input int ts);
        p_ch.push_back(ch);
        p_ts.push_back(ts);
    endtask

    // Expected stream: earliest in-window pulse per channel, ascending channel order.
    task automatic fill_expected();
        int first[N_CH];
        int cnt;
        for (int c = 0; c < N_CH; c++) first[c] = -1;
        for (int k = 0; k < p_ch.size(); k++) begin
            if (p_ts[k] < WINDOW && (first[p_ch[k]] < 0 || p_ts[k] < first[p_ch[k]]))
                first[p_ch[k]] = p_ts[k];
        end
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b0, 16'(evt_exp)});
        cnt = 0;
        for (int c = 0; c < N_CH; c++) begin
            if (first[c] >= 0) begin
                exp_q.push_back({2'b00, 8'(c), 8'(first[c])});
                cnt++;
            end
        end
        exp_q.push_back({1'b0, 1'b1, 16'(cnt)});
    endtask

    // Drive trigger at relative cycle 0 and the tube pulses at their offsets.
    task automatic drive_event(input string name);
        logic [N_CH-1:0] mask;
        for (int t = 0; t < WINDOW + 8; t++) begin
            @(posedge clk100);
            #1;
            scin_coin = (t == 0) || (extra_ts >= 2 && t == extra_ts);
            mask = '0;
            for (int k = 0; k < p_ch.size(); k++) begin
                if (p_ts[k] == t) mask[p_ch[k]] = 1'b1;
            end
            tube_hit = mask;
            if (t == 100) check({name, "_busy_armed"}, busy, 1);
        end
        @(posedge clk100);
        #1;
        scin_coin = 1'b0;
        tube_hit  = '0;
        if (extra_ts >= 2 && missed_exp < 65535) missed_exp++;
    endtask

    task automatic run_event(input string name);
        int guard;
        int n;
        fill_expected();
        got_q.delete();
        drive_event(name);
        guard = 0;
        @(negedge clk100);
        while (busy !== 1'b0 && guard < 5000) begin
            @(negedge clk100);
            guard++;
        end
        check({name, "_done"}, busy, 0);
        check({name, "_nwords"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", name, i), got_q[i], exp_q[i]);
        end
        evt_exp++;
        check({name, "_missed"}, missed_trig, missed_exp);
        repeat (5) @(posedge clk100);
    endtask

    initial begin
        evt_exp    = 0;
        missed_exp = 0;
        clear_event();
        repeat (3) @(posedge clk100);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eof", out_eof, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_missed", missed_trig, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk100);

        clear_event(); add_hit(0, 5); add_hit(3, 17);
        run_event("basic");

        clear_event(); add_hit(3, 10); add_hit(3, 40);
        run_event("first_hit");

        clear_event(); add_hit(7, 0); add_hit(8, WINDOW - 1); add_hit(9, WINDOW);
        run_event("window_edges");

        clear_event(); add_hit(1, 20); add_hit(2, 20); add_hit(31, 20); add_hit(4, 60);
        extra_ts = 50;
        run_event("missed");

        ready_mode = 2; stall_left = 10; stall_seen = 0;
        clear_event(); add_hit(0, 5); add_hit(3, 17);
        run_event("stall");
        check("stall_cycles", stall_seen, 10);

        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            clear_event();
            for (int k = 0; k < $urandom_range(0, 12); k++)
                add_hit($urandom_range(0, N_CH - 1), $urandom_range(0, WINDOW + 3));
            if ($urandom_range(0, 2) == 0) extra_ts = $urandom_range(2, WINDOW + 7);
            run_event($sformatf("rand%0d", r));
        end

        // Reset in the middle of draining.
        ready_mode = 0;
        clear_event(); add_hit(0, 5); add_hit(3, 17); add_hit(31, 100);
        drive_event("rst_mid");
        check("rst_mid_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_sof", out_sof, 0);
        check("rst_mid_eof", out_eof, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_missed", missed_trig, 0);
        repeat (3) @(posedge clk100);
        #1;
        rst_n      = 1'b1;
        evt_exp    = 0;
        missed_exp = 0;
        repeat (5) @(posedge clk100);
        clear_event(); add_hit(5, 33);
        run_event("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
